// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
//   fetchState_t         : fetch FSM state encoding (RUN / HOLD_TARGET)
//   NOP_INSTRUCTION      : word loaded into IF/ID for a bubble
//   DEFAULT_RESET_VECTOR : default first fetch address after reset
//   pcPlus4()            : sequential next address, wraps modulo 2^32
package instruction_fetch_stage_pkg;

    typedef enum logic [0:0] {
        RUN         = 1'b0,
        HOLD_TARGET = 1'b1
    } fetchState_t;

    localparam logic [31:0] NOP_INSTRUCTION      = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
//   imemAddress : fetch address driven by the fetch stage
//   imemData    : instruction word returned for imemAddress
//   imemReady   : imemData is valid this cycle
// master = fetch stage side, slave = memory side.
interface instruction_fetch_stage_if;

    logic [31:0] imemAddress;
    logic [31:0] imemData;
    logic        imemReady;

    modport master (
        output imemAddress,
        input  imemData,
        input  imemReady
    );

    modport slave (
        input  imemAddress,
        output imemData,
        output imemReady
    );

endinterface

// File: rtl/instruction_fetch_stage_next_pc_select.sv
// Redirect target computation for the fetch stage (purely combinational).
//   instrIndex         : low 26 bits of the ID-stage instruction
//   idPcPlus4          : PC+4 of the ID-stage instruction
//   jumpRegisterTarget : forwarded rs value for JR
//   idValid/shouldStall: gate the redirect (only a real, unstalled ID op)
//   isJumpRegister > isJump > isBranchTaken : redirect priority
//   redirectValid      : a redirect must be honoured this cycle
//   redirectTarget     : address to fetch after the delay slot
module next_pc_select
    import instruction_fetch_stage_pkg::*;
(
    input  logic [25:0] instrIndex,
    input  logic [31:0] idPcPlus4,
    input  logic [31:0] jumpRegisterTarget,
    input  logic        idValid,
    input  logic        shouldStall,
    input  logic        isBranchTaken,
    input  logic        isJump,
    input  logic        isJumpRegister,
    output logic        redirectValid,
    output logic [31:0] redirectTarget
);

    logic [31:0] branchTarget_s;
    logic [31:0] jumpTarget_s;

    // Word offset is sign-extended then scaled by 4; the add wraps naturally.
    assign branchTarget_s = idPcPlus4 + {{14{instrIndex[15]}}, instrIndex[15:0], 2'b00};
    assign jumpTarget_s   = {idPcPlus4[31:28], instrIndex, 2'b00};

    // Priority select of the redirect target and its qualification.
    always_comb begin
        redirectTarget = branchTarget_s;
        if (isJumpRegister) begin
            redirectTarget = jumpRegisterTarget;
        end else if (isJump) begin
            redirectTarget = jumpTarget_s;
        end else begin
            redirectTarget = branchTarget_s;
        end
        redirectValid = idValid & ~shouldStall & (isJumpRegister | isJump | isBranchTaken);
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage with one architectural delay slot.
//   clock, resetN      : clock and synchronous active-low reset
//   shouldStall        : hold PC, IF/ID, FSM and pending target
//   isBranchTaken, isJump, isJumpRegister, jumpRegisterTarget : ID redirects
//   imem               : instruction memory bus (master side)
//   idInstruction, idPcPlus4, idValid : IF/ID pipeline register
// When a redirect arrives while memory is not ready, the target is parked in
// pendingTarget (HOLD_TARGET) until the delay-slot fetch completes.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
)
(
    input  logic                             clock,
    input  logic                             resetN,
    input  logic                             shouldStall,
    input  logic                             isBranchTaken,
    input  logic                             isJump,
    input  logic                             isJumpRegister,
    input  logic [31:0]                      jumpRegisterTarget,
    instruction_fetch_stage_if.master        imem,
    output logic [31:0]                      idInstruction,
    output logic [31:0]                      idPcPlus4,
    output logic                             idValid
);

    fetchState_t state_r, stateNext_s;
    logic [31:0] pc_r, pcNext_s;
    logic [31:0] pendingTarget_r, pendingTargetNext_s;
    logic [31:0] idInstruction_r, idInstructionNext_s;
    logic [31:0] idPcPlus4_r, idPcPlus4Next_s;
    logic        idValid_r, idValidNext_s;
    logic        redirectValid_s;
    logic [31:0] redirectTarget_s;

    next_pc_select u_nextPcSelect (
        .instrIndex         (idInstruction_r[25:0]),
        .idPcPlus4          (idPcPlus4_r),
        .jumpRegisterTarget (jumpRegisterTarget),
        .idValid            (idValid_r),
        .shouldStall        (shouldStall),
        .isBranchTaken      (isBranchTaken),
        .isJump             (isJump),
        .isJumpRegister     (isJumpRegister),
        .redirectValid      (redirectValid_s),
        .redirectTarget     (redirectTarget_s)
    );

    assign imem.imemAddress = pc_r;
    assign idInstruction    = idInstruction_r;
    assign idPcPlus4        = idPcPlus4_r;
    assign idValid          = idValid_r;

    // Next-state logic: everything holds by default (covers stall).
    always_comb begin
        stateNext_s         = state_r;
        pcNext_s            = pc_r;
        pendingTargetNext_s = pendingTarget_r;
        idInstructionNext_s = idInstruction_r;
        idPcPlus4Next_s     = idPcPlus4_r;
        idValidNext_s       = idValid_r;
        if (shouldStall) begin
            stateNext_s = state_r;
        end else begin
            // Default for an unstalled cycle: a bubble enters IF/ID.
            idInstructionNext_s = NOP_INSTRUCTION;
            idPcPlus4Next_s     = 32'h0000_0000;
            idValidNext_s       = 1'b0;
            case (state_r)
                RUN: begin
                    if (imem.imemReady) begin
                        idInstructionNext_s = imem.imemData;
                        idPcPlus4Next_s     = pcPlus4(pc_r);
                        idValidNext_s       = 1'b1;
                        pcNext_s            = redirectValid_s ? redirectTarget_s : pcPlus4(pc_r);
                        stateNext_s         = RUN;
                    end else if (redirectValid_s) begin
                        // Delay slot still outstanding: park the target.
                        pendingTargetNext_s = redirectTarget_s;
                        stateNext_s         = HOLD_TARGET;
                    end else begin
                        stateNext_s = RUN;
                    end
                end
                HOLD_TARGET: begin
                    if (imem.imemReady) begin
                        idInstructionNext_s = imem.imemData;
                        idPcPlus4Next_s     = pcPlus4(pc_r);
                        idValidNext_s       = 1'b1;
                        pcNext_s            = pendingTarget_r;
                        stateNext_s         = RUN;
                    end else begin
                        stateNext_s = HOLD_TARGET;
                    end
                end
                default: begin
                    stateNext_s = RUN;
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_r         <= RUN;
            pc_r            <= RESET_VECTOR;
            pendingTarget_r <= 32'h0000_0000;
            idInstruction_r <= NOP_INSTRUCTION;
            idPcPlus4_r     <= 32'h0000_0000;
            idValid_r       <= 1'b0;
        end else begin
            state_r         <= stateNext_s;
            pc_r            <= pcNext_s;
            pendingTarget_r <= pendingTargetNext_s;
            idInstruction_r <= idInstructionNext_s;
            idPcPlus4_r     <= idPcPlus4Next_s;
            idValid_r       <= idValidNext_s;
        end
    end

endmodule
